// File: rtl/cplx_mult_stream_if.sv
// ---------------------------------------------------------------------------
// cplx_mult_stream_if
//   Streaming bundle for the complex multiplier: the input sample channel
//   (a, b, conj with valid/ready) and the output result channel (y with
//   valid/ready).
//   Modports:
//     slave  - the multiplier side: consumes a/b/conj, produces y.
//     master - the producer/consumer side around the multiplier.
//   Signals:
//     a_in      2*DATA_W  {re,im} data sample, re in the upper half
//     b_in      2*COEF_W  {re,im} coefficient, re in the upper half
//     conj_in   1         multiply by conj(b) for this sample
//     in_valid  1         input sample valid
//     in_ready  1         multiplier accepts a sample this cycle
//     y_out     2*OUT_W   {re,im} result, re in the upper half
//     out_valid 1         y_out valid
//     out_ready 1         downstream accepts y_out
// ---------------------------------------------------------------------------
interface cplx_mult_stream_if #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int OUT_W  = 16
);
  logic [2*DATA_W-1:0] a_in;
  logic [2*COEF_W-1:0] b_in;
  logic                conj_in;
  logic                in_valid;
  logic                in_ready;
  logic [2*OUT_W-1:0]  y_out;
  logic                out_valid;
  logic                out_ready;

  modport slave (
    input  a_in, b_in, conj_in, in_valid, out_ready,
    output in_ready, y_out, out_valid
  );

  modport master (
    output a_in, b_in, conj_in, in_valid, out_ready,
    input  in_ready, y_out, out_valid
  );
endinterface

// File: rtl/cplx_mult_stream.sv
// ---------------------------------------------------------------------------
// cplx_mult_stream
//   Fully pipelined fixed-point complex multiplier: y = a*b, or a*conj(b)
//   when conj is set for that sample. The full-precision result is rounded
//   half up, scaled by 2^-FRAC_SHIFT and saturated to OUT_W bits.
//   Four register stages, one sample per cycle, the whole pipeline stalls
//   together when the output is held by the consumer.
//   Ports:
//     clk       rising-edge clock
//     rst       asynchronous active-low reset
//     bus       stream interface (slave side): a/b/conj in, y out
//     sat_clr   synchronous clear of sat_flag and sat_cnt
//     sat_flag  sticky: some output component was clamped
//     sat_cnt   number of clamped output samples, saturating at all-ones
// ---------------------------------------------------------------------------
module cplx_mult_stream #(
  parameter int DATA_W     = 16,
  parameter int COEF_W     = 16,
  parameter int OUT_W      = 16,
  parameter int FRAC_SHIFT = 15,
  parameter int CNT_W      = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  cplx_mult_stream_if.slave    bus,
  input  logic                 sat_clr,
  output logic                 sat_flag,
  output logic [CNT_W-1:0]     sat_cnt
);

  localparam int PW = DATA_W + COEF_W;  // product width
  localparam int SW = PW + 1;           // sum width

  // Rounding constant and clamp bounds, one bit wider than the sums so the
  // rounding add can never wrap.
  localparam logic signed [SW:0] RND   = $signed((SW+1)'(1) << (FRAC_SHIFT - 1));
  localparam logic signed [SW:0] MAX_V = $signed((SW+1)'({(OUT_W-1){1'b1}}));
  localparam logic signed [SW:0] MIN_V = -MAX_V - 1;
  localparam logic [OUT_W-1:0]   MAX_O = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0]   MIN_O = {1'b1, {(OUT_W-1){1'b0}}};

  // Returns {clipped, value}.
  function automatic logic [OUT_W:0] round_sat(input logic signed [SW-1:0] s);
    logic signed [SW:0] r;
    r = $signed((SW+1)'(s)) + RND;
    r = r >>> FRAC_SHIFT;
    if (r > MAX_V)      return {1'b1, MAX_O};
    else if (r < MIN_V) return {1'b1, MIN_O};
    else                return {1'b0, r[OUT_W-1:0]};
  endfunction

  logic en;

  // S1
  logic signed [DATA_W-1:0] a_re_q, a_re_d, a_im_q, a_im_d;
  logic signed [COEF_W-1:0] b_re_q, b_re_d, b_im_q, b_im_d;
  logic                     conj1_q, conj1_d, v1_q, v1_d;
  // S2
  logic signed [PW-1:0]     p_rr_q, p_rr_d, p_ii_q, p_ii_d;
  logic signed [PW-1:0]     p_ri_q, p_ri_d, p_ir_q, p_ir_d;
  logic                     conj2_q, conj2_d, v2_q, v2_d;
  // S3
  logic signed [SW-1:0]     s_re_q, s_re_d, s_im_q, s_im_d;
  logic                     v3_q, v3_d;
  // S4 / output
  logic [2*OUT_W-1:0]       y_out_q, y_out_d;
  logic                     out_valid_q, out_valid_d;
  logic                     sat_flag_q, sat_flag_d;
  logic [CNT_W-1:0]         sat_cnt_q, sat_cnt_d;

  logic [OUT_W:0]           rs_re, rs_im;
  logic                     sat_event;

  // A slot can only leave S4 when the output register is free or being read.
  assign en           = !out_valid_q || bus.out_ready;
  assign bus.in_ready = en;
  assign bus.y_out    = y_out_q;
  assign bus.out_valid = out_valid_q;
  assign sat_flag     = sat_flag_q;
  assign sat_cnt      = sat_cnt_q;

  always_comb begin
    a_re_d      = a_re_q;
    a_im_d      = a_im_q;
    b_re_d      = b_re_q;
    b_im_d      = b_im_q;
    conj1_d     = conj1_q;
    v1_d        = v1_q;
    p_rr_d      = p_rr_q;
    p_ii_d      = p_ii_q;
    p_ri_d      = p_ri_q;
    p_ir_d      = p_ir_q;
    conj2_d     = conj2_q;
    v2_d        = v2_q;
    s_re_d      = s_re_q;
    s_im_d      = s_im_q;
    v3_d        = v3_q;
    y_out_d     = y_out_q;
    out_valid_d = out_valid_q;

    rs_re = round_sat(s_re_q);
    rs_im = round_sat(s_im_q);

    if (en) begin
      a_re_d  = $signed(bus.a_in[2*DATA_W-1:DATA_W]);
      a_im_d  = $signed(bus.a_in[DATA_W-1:0]);
      b_re_d  = $signed(bus.b_in[2*COEF_W-1:COEF_W]);
      b_im_d  = $signed(bus.b_in[COEF_W-1:0]);
      conj1_d = bus.conj_in;
      v1_d    = bus.in_valid;

      p_rr_d  = $signed(PW'(a_re_q)) * $signed(PW'(b_re_q));
      p_ii_d  = $signed(PW'(a_im_q)) * $signed(PW'(b_im_q));
      p_ri_d  = $signed(PW'(a_re_q)) * $signed(PW'(b_im_q));
      p_ir_d  = $signed(PW'(a_im_q)) * $signed(PW'(b_re_q));
      conj2_d = conj1_q;
      v2_d    = v1_q;

      // Conjugating b flips the sign of bi, which swaps the sign of the
      // ai*bi term in re and of the ar*bi term in im.
      if (conj2_q) begin
        s_re_d = $signed(SW'(p_rr_q)) + $signed(SW'(p_ii_q));
        s_im_d = $signed(SW'(p_ir_q)) - $signed(SW'(p_ri_q));
      end else begin
        s_re_d = $signed(SW'(p_rr_q)) - $signed(SW'(p_ii_q));
        s_im_d = $signed(SW'(p_ri_q)) + $signed(SW'(p_ir_q));
      end
      v3_d = v2_q;

      y_out_d     = {rs_re[OUT_W-1:0], rs_im[OUT_W-1:0]};
      out_valid_d = v3_q;
    end
  end

  // One event per valid sample entering the output register, even when both
  // components clamp.
  assign sat_event = en && v3_q && (rs_re[OUT_W] || rs_im[OUT_W]);

  always_comb begin
    sat_flag_d = sat_flag_q;
    sat_cnt_d  = sat_cnt_q;
    if (sat_clr) begin
      sat_flag_d = 1'b0;
      sat_cnt_d  = '0;
    end else if (sat_event) begin
      sat_flag_d = 1'b1;
      if (sat_cnt_q != {CNT_W{1'b1}}) sat_cnt_d = sat_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_re_q      <= '0;
      a_im_q      <= '0;
      b_re_q      <= '0;
      b_im_q      <= '0;
      conj1_q     <= 1'b0;
      v1_q        <= 1'b0;
      p_rr_q      <= '0;
      p_ii_q      <= '0;
      p_ri_q      <= '0;
      p_ir_q      <= '0;
      conj2_q     <= 1'b0;
      v2_q        <= 1'b0;
      s_re_q      <= '0;
      s_im_q      <= '0;
      v3_q        <= 1'b0;
      y_out_q     <= '0;
      out_valid_q <= 1'b0;
      sat_flag_q  <= 1'b0;
      sat_cnt_q   <= '0;
    end else begin
      a_re_q      <= a_re_d;
      a_im_q      <= a_im_d;
      b_re_q      <= b_re_d;
      b_im_q      <= b_im_d;
      conj1_q     <= conj1_d;
      v1_q        <= v1_d;
      p_rr_q      <= p_rr_d;
      p_ii_q      <= p_ii_d;
      p_ri_q      <= p_ri_d;
      p_ir_q      <= p_ir_d;
      conj2_q     <= conj2_d;
      v2_q        <= v2_d;
      s_re_q      <= s_re_d;
      s_im_q      <= s_im_d;
      v3_q        <= v3_d;
      y_out_q     <= y_out_d;
      out_valid_q <= out_valid_d;
      sat_flag_q  <= sat_flag_d;
      sat_cnt_q   <= sat_cnt_d;
    end
  end

endmodule

// File: tb/tb_cplx_mult_stream.sv
// ---------------------------------------------------------------------------
// tb_cplx_mult_stream
//   Scoreboard bench for cplx_mult_stream: every accepted input pushes its
//   expected result, every output transfer pops and compares in order.
// ---------------------------------------------------------------------------
module tb_cplx_mult_stream;

  logic        clk = 1'b0;
  logic        rst;
  logic        sat_clr;
  logic        sat_flag;
  logic [15:0] sat_cnt;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] exp_q[$];
  logic        prev_stall = 1'b0;
  logic [31:0] prev_y     = '0;
  logic        t5_done;

  cplx_mult_stream_if #(.DATA_W(16), .COEF_W(16), .OUT_W(16)) bus ();

  cplx_mult_stream #(
    .DATA_W(16), .COEF_W(16), .OUT_W(16), .FRAC_SHIFT(15), .CNT_W(16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .sat_clr  (sat_clr),
    .sat_flag (sat_flag),
    .sat_cnt  (sat_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] sat16(input longint v);
    longint r;
    r = (v + 64'sd16384) >>> 15;
    if (r > 32767)  return 16'h7FFF;
    if (r < -32768) return 16'h8000;
    return r[15:0];
  endfunction

  function automatic logic [31:0] model(input logic [15:0] ar, input logic [15:0] ai,
                                        input logic [15:0] br, input logic [15:0] bi,
                                        input logic cj);
    longint xr, xi, yr, yi, re, im;
    xr = longint'($signed(ar));
    xi = longint'($signed(ai));
    yr = longint'($signed(br));
    yi = longint'($signed(bi));
    if (cj) begin
      re = xr * yr + xi * yi;
      im = xi * yr - xr * yi;
    end else begin
      re = xr * yr - xi * yi;
      im = xr * yi + xi * yr;
    end
    return {sat16(re), sat16(im)};
  endfunction

  // Call at a point away from the clock edges; returns at posedge+1 after
  // the sample was accepted, with in_valid dropped.
  task automatic send_exp(input logic [15:0] ar, input logic [15:0] ai,
                          input logic [15:0] br, input logic [15:0] bi,
                          input logic cj, input logic [31:0] exp);
    bit ok = 0;
    bus.a_in     = {ar, ai};
    bus.b_in     = {br, bi};
    bus.conj_in  = cj;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        exp_q.push_back(exp);
        ok = 1;
      end
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    if (!ok) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic send(input logic [15:0] ar, input logic [15:0] ai,
                      input logic [15:0] br, input logic [15:0] bi, input logic cj);
    send_exp(ar, ai, br, bi, cj, model(ar, ai, br, bi, cj));
  endtask

  // Called right after send(): counts edges until out_valid (accepting edge = 1).
  task automatic measure_lat(input string tag);
    int lat = 1;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk(tag, 32'(lat), 32'd4);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 500 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    chk("drain", 32'(exp_q.size()), 32'd0);
  endtask

  // Output monitor / scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          chk("hold_valid", {31'd0, bus.out_valid}, 32'd1);
          chk("hold_y", bus.y_out, prev_y);
        end
        if (bus.out_valid && !bus.out_ready)
          chk("stall_in_ready", {31'd0, bus.in_ready}, 32'd0);
        if (bus.out_valid && bus.out_ready) begin
          if (exp_q.size() == 0) chk("unexpected_out", 32'd0, 32'd1);
          else chk("y_out", bus.y_out, exp_q.pop_front());
        end
        prev_stall = bus.out_valid && !bus.out_ready;
        prev_y     = bus.y_out;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst           = 1'b0;
    sat_clr       = 1'b0;
    bus.a_in      = '0;
    bus.b_in      = '0;
    bus.conj_in   = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    t5_done       = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_y_out", bus.y_out, 32'd0);
    chk("rst_sat_flag", {31'd0, sat_flag}, 32'd0);
    chk("rst_sat_cnt", {16'd0, sat_cnt}, 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);

    // T1 basic + latency
    send_exp(16'h4000, 16'h0000, 16'h4000, 16'h4000, 1'b0, 32'h2000_2000);
    measure_lat("t1_latency");
    wait_drain();
    chk("t1_sat_flag", {31'd0, sat_flag}, 32'd0);

    // T2 conj
    send_exp(16'h0000, 16'h4000, 16'h4000, 16'h4000, 1'b1, 32'h2000_2000);
    send_exp(16'h0000, 16'h4000, 16'h4000, 16'h4000, 1'b0, 32'hE000_2000);
    // T3 rounding
    send_exp(16'h0001, 16'h0000, 16'h4000, 16'h0000, 1'b0, 32'h0001_0000);
    send_exp(16'hFFFF, 16'h0000, 16'h4000, 16'h0000, 1'b0, 32'h0000_0000);
    send_exp(16'hFFFE, 16'h0000, 16'h4000, 16'h0000, 1'b0, 32'hFFFF_0000);
    wait_drain();
    chk("t3_sat_flag", {31'd0, sat_flag}, 32'd0);
    chk("t3_sat_cnt", {16'd0, sat_cnt}, 32'd0);

    // T4 saturation
    send_exp(16'h8000, 16'h8000, 16'h8000, 16'h8000, 1'b0, 32'h0000_7FFF);
    wait_drain();
    chk("t4_sat_flag", {31'd0, sat_flag}, 32'd1);
    chk("t4_sat_cnt1", {16'd0, sat_cnt}, 32'd1);
    send_exp(16'h8000, 16'h8000, 16'h8000, 16'h8000, 1'b1, 32'h7FFF_0000);
    wait_drain();
    chk("t4_sat_cnt2", {16'd0, sat_cnt}, 32'd2);
    sat_clr = 1'b1;
    @(posedge clk);
    #1;
    sat_clr = 1'b0;
    chk("t4_clr_flag", {31'd0, sat_flag}, 32'd0);
    chk("t4_clr_cnt", {16'd0, sat_cnt}, 32'd0);

    // T5 backpressure with a random stream
    fork
      begin
        for (int i = 0; i < 32; i++)
          send($urandom, $urandom, $urandom, $urandom, 1'($urandom_range(0, 1)));
        t5_done = 1'b1;
      end
      begin
        for (int i = 0; i < 2000 && !t5_done; i++) begin
          @(posedge clk);
          #1;
          if (i >= 5 && i < 15) bus.out_ready = 1'b0;
          else bus.out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    bus.out_ready = 1'b1;
    wait_drain();

    // T6 reset with three samples in flight
    send(16'h1111, 16'h2222, 16'h3333, 16'h4444, 1'b0);
    send(16'h5555, 16'h6666, 16'h7777, 16'h0123, 1'b1);
    send(16'h0456, 16'h0789, 16'h0ABC, 16'h0DEF, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    chk("t6_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("t6_y_out", bus.y_out, 32'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    send_exp(16'h4000, 16'h0000, 16'h0000, 16'h4000, 1'b0, 32'h0000_2000);
    measure_lat("t6_latency");
    repeat (10) @(posedge clk);
    wait_drain();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
